// File: rtl/uart_param_core.sv
// Full-duplex UART: baud-timed transmitter and mid-bit-sampling receiver with a
// fixed frame format (data width, parity mode, stop bits) chosen at elaboration.
module uart_param_core #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int BCW = $clog2(2 * CLKS_PER_BIT);
  localparam int BTW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_END  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_END = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] STOP_END = BCW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BTW-1:0] LAST_BIT = BTW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BAUD_ONE = BCW'(1);
  localparam logic [BTW-1:0] BIT_ONE  = BTW'(1);
  localparam bit             PAR_EN   = (PARITY != 0);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3,
    RX_STOP = 3'd4, RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  tx_state_t             tx_state_q, tx_state_d;
  logic [BCW-1:0]        tx_baud_q, tx_baud_d;
  logic [BTW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  txd_q, txd_d;
  logic                  tx_ready_q, tx_ready_d;

  // TX state register; txd and tx_ready are registered from next-state values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // TX next state and bit timing
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_shift_d = tx_data;
          tx_par_d   = parity_of(tx_data);
        end else begin
          tx_baud_d = '0;
        end
      end
      TX_START: begin
        if (tx_baud_q == BIT_END) begin
          tx_state_d = TX_DATA;
          tx_baud_d  = '0;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d  = '0;
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + BIT_ONE;
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      TX_PARITY: begin
        if (tx_baud_q == BIT_END) begin
          tx_state_d = TX_STOP;
          tx_baud_d  = '0;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      TX_STOP: begin
        if (tx_baud_q == STOP_END) begin
          tx_state_d = TX_IDLE;
          tx_baud_d  = '0;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_baud_d  = '0;
      end
    endcase
  end

  // TX line level and ready for the upcoming cycle
  always_comb begin
    txd_d      = 1'b1;
    tx_ready_d = 1'b0;
    case (tx_state_d)
      TX_IDLE:   tx_ready_d = 1'b1;
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shift_d[0];
      TX_PARITY: txd_d = tx_par_d;
      TX_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd      = txd_q;
  assign tx_ready = tx_ready_q;

  rx_state_t             rx_state_q, rx_state_d;
  logic                  rx_meta_q, rs_q;
  logic [BCW-1:0]        rx_baud_q, rx_baud_d;
  logic [BTW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_parity_err_q, rx_parity_err_d;
  logic                  rx_frame_err_q, rx_frame_err_d;

  // RX synchroniser, state and delivered-frame registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q       <= 1'b1;
      rs_q            <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_baud_q       <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_perr_q       <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q       <= rxd;
      rs_q            <= rx_meta_q;
      rx_state_q      <= rx_state_d;
      rx_baud_q       <= rx_baud_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_perr_q       <= rx_perr_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
    end
  end

  // RX next state: half-bit start check, then samples at bit centres
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = '0;
        if (!rs_q) begin
          rx_state_d = RX_START;
          rx_perr_d  = 1'b0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_END) begin
          rx_state_d = rs_q ? RX_IDLE : RX_DATA;
          rx_baud_d  = '0;
          rx_bit_d   = '0;
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BIT_END) begin
          rx_baud_d  = '0;
          rx_shift_d = {rs_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
            rx_bit_d   = '0;
          end else begin
            rx_bit_d = rx_bit_q + BIT_ONE;
          end
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_PARITY: begin
        if (rx_baud_q == BIT_END) begin
          rx_state_d = RX_STOP;
          rx_baud_d  = '0;
          rx_perr_d  = rs_q ^ parity_of(rx_shift_q);
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BIT_END) begin
          rx_state_d = rs_q ? RX_IDLE : RX_WAIT_HIGH;
          rx_baud_d  = '0;
        end else begin
          rx_baud_d = rx_baud_q + BAUD_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        rx_baud_d = '0;
        if (rs_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT_HIGH;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_baud_d  = '0;
      end
    endcase
  end

  // RX delivery on the stop-bit sample; data and flags hold between frames
  always_comb begin
    rx_valid_d      = 1'b0;
    rx_data_d       = rx_data_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    if (rx_state_q == RX_STOP && rx_baud_q == BIT_END) begin
      rx_valid_d      = 1'b1;
      rx_data_d       = rx_shift_q;
      rx_parity_err_d = rx_perr_q;
      rx_frame_err_d  = ~rs_q;
    end else begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Scoreboard bench for uart_param_core: three instances (8N1, 7E1, 8N2) with
// loopback or injected serial input; a monitor pops expected frames on rx_valid.
module tb_uart_param_core;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  tx_valid_v;
  logic [8:0]  tx_data_v [3];
  logic [2:0]  tx_ready_v, txd_v, rxd_v, rx_valid_v, perr_v, ferr_v;
  logic [7:0]  rd0, rd2;
  logic [6:0]  rd1;
  logic [1:0]  inj_sel;
  logic        inj_line;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  assign rxd_v[0] = (inj_sel == 2'd0) ? inj_line : txd_v[0];
  assign rxd_v[1] = (inj_sel == 2'd1) ? inj_line : txd_v[1];
  assign rxd_v[2] = (inj_sel == 2'd2) ? inj_line : txd_v[2];

  uart_param_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_data(tx_data_v[0][7:0]), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_v[0]), .txd(txd_v[0]), .rxd(rxd_v[0]), .rx_data(rd0),
    .rx_valid(rx_valid_v[0]), .rx_parity_err(perr_v[0]), .rx_frame_err(ferr_v[0]));

  uart_param_core #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_data(tx_data_v[1][6:0]), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_v[1]), .txd(txd_v[1]), .rxd(rxd_v[1]), .rx_data(rd1),
    .rx_valid(rx_valid_v[1]), .rx_parity_err(perr_v[1]), .rx_frame_err(ferr_v[1]));

  uart_param_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .tx_data(tx_data_v[2][7:0]), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_v[2]), .txd(txd_v[2]), .rxd(rxd_v[2]), .rx_data(rd2),
    .rx_valid(rx_valid_v[2]), .rx_parity_err(perr_v[2]), .rx_frame_err(ferr_v[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e = {d, pe, fe};
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic logic [8:0] rx_data_of(input int k);
    case (k)
      0: return {1'b0, rd0};
      1: return {2'b00, rd1};
      default: return {1'b0, rd2};
    endcase
  endfunction

  // Monitor: every rx_valid pulse must match the oldest expected frame of that instance
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_valid_v[k]) begin
        exp_t e;
        bit   have;
        have = 1'b1;
        e    = '0;
        case (k)
          0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
          1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
          default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
        endcase
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected dut%0d: got rx_valid data %0h, expected no frame (cycle %0d)",
                   k, rx_data_of(k), cyc);
        end else begin
          check($sformatf("rx_data dut%0d", k), rx_data_of(k), e.data);
          check($sformatf("rx_parity_err dut%0d", k), perr_v[k], e.perr);
          check($sformatf("rx_frame_err dut%0d", k), ferr_v[k], e.ferr);
        end
      end
    end
  end

  // Drive raw serial bits LSB first on the injected line, one bit time each
  task automatic drive_bits(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      inj_line = pat[i];
      repeat (CPB) @(negedge clk);
    end
    inj_line = 1'b1;
  endtask

  task automatic tx_send(input int k, input logic [8:0] d, input int f, input bit keep,
                         output int hs);
    int n;
    tx_data_v[k]  = d;
    tx_valid_v[k] = 1'b1;
    n = 0;
    while (!tx_ready_v[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    hs = cyc;
    if (!tx_ready_v[k]) begin
      check($sformatf("tx_ready_timeout dut%0d", k), 32'd0, 32'd1);
      tx_valid_v[k] = 1'b0;
    end else begin
      @(negedge clk);
      hs = cyc;
      if (!keep) tx_valid_v[k] = 1'b0;
      check($sformatf("tx_start_bit dut%0d", k), txd_v[k], 1'b0);
      check($sformatf("tx_ready_busy dut%0d", k), tx_ready_v[k], 1'b0);
      n = 0;
      while (!tx_ready_v[k] && n < f + 50) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("tx_frame_cycles dut%0d", k), n, f);
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("rx_scoreboard_drained", q0.size() + q1.size() + q2.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int h1, h2;
    reset      = 1'b0;
    tx_valid_v = 3'b000;
    for (int i = 0; i < 3; i++) tx_data_v[i] = 9'd0;
    inj_sel    = 2'd3;
    inj_line   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", txd_v, 3'b111);
    check("reset_tx_ready", tx_ready_v, 3'b111);
    check("reset_rx_valid", rx_valid_v, 3'b000);
    check("reset_flags", {perr_v, ferr_v}, 6'd0);
    check("reset_rx_data", {rd0, rd1, rd2}, 23'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 loopback
    push(0, 9'h0A5, 1'b0, 1'b0);
    tx_send(0, 9'h0A5, 160, 1'b0, h1);
    wait_drain(200);

    // 7E1 loopback, then an injected frame whose parity bit is flipped
    push(1, 9'h035, 1'b0, 1'b0);
    tx_send(1, 9'h035, 160, 1'b0, h1);
    push(1, 9'h007, 1'b0, 1'b0);
    tx_send(1, 9'h007, 160, 1'b0, h1);
    wait_drain(200);
    inj_sel = 2'd1;
    push(1, 9'h035, 1'b1, 1'b0);
    drive_bits({6'h3F, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
    repeat (CPB) @(negedge clk);
    wait_drain(200);

    // 8N1 frame error with the line held low, then a good frame
    inj_sel = 2'd0;
    push(0, 9'h081, 1'b0, 1'b1);
    drive_bits({3'b111, 3'b000, 1'b0, 8'h81, 1'b0}, 13);
    repeat (2 * CPB) @(negedge clk);
    check("frame_err_single_valid", q0.size(), 32'd0);
    push(0, 9'h042, 1'b0, 1'b0);
    drive_bits({7'h7F, 8'h42, 1'b0}, 10);
    repeat (CPB) @(negedge clk);
    wait_drain(200);

    // short low glitch is not a start bit
    inj_line = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    inj_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    push(0, 9'h03C, 1'b0, 1'b0);
    drive_bits({7'h7F, 8'h3C, 1'b0}, 10);
    repeat (CPB) @(negedge clk);
    wait_drain(200);
    inj_sel = 2'd3;
    repeat (4) @(negedge clk);

    // 8N2 back-to-back with tx_valid held
    push(2, 9'h000, 1'b0, 1'b0);
    push(2, 9'h0FF, 1'b0, 1'b0);
    tx_send(2, 9'h000, 176, 1'b1, h1);
    tx_send(2, 9'h0FF, 176, 1'b0, h2);
    check("b2b_start_spacing", h2 - h1, 32'd177);
    wait_drain(200);

    // reset during TX data bit 3 and RX data bit 5
    inj_sel = 2'd0;
    fork
      drive_bits({7'h7F, 8'hE5, 1'b0}, 10);
      begin
        repeat (32) @(negedge clk);
        tx_data_v[0]  = 9'h0C3;
        tx_valid_v[0] = 1'b1;
        @(negedge clk);
        tx_valid_v[0] = 1'b0;
        repeat (71) @(negedge clk);
        check("pre_reset_tx_busy", tx_ready_v[0], 1'b0);
        reset = 1'b0;
        #1;
        check("mid_reset_txd", txd_v[0], 1'b1);
        check("mid_reset_tx_ready", tx_ready_v[0], 1'b1);
        check("mid_reset_rx_data", rd0, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    check("post_reset_no_frame", q0.size(), 32'd0);
    inj_sel = 2'd3;
    repeat (2) @(negedge clk);
    push(0, 9'h05A, 1'b0, 1'b0);
    tx_send(0, 9'h05A, 160, 1'b0, h1);
    wait_drain(200);
    repeat (20) @(negedge clk);
    check("rx_data_held", rd0, 8'h5A);
    check("rx_flags_held", {perr_v[0], ferr_v[0]}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
